// File: rtl/facto_requester.sv
// Host-side initiator for the factorial engine: takes operands on a valid/ready
// request channel, runs one engine computation per operand and returns the result.
module facto_requester #(
  parameter int X_W     = 4,
  parameter int F_W     = 32,
  parameter int MAX_X   = 12,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [X_W-1:0]   req_x,
  output logic             eng_start,
  output logic [X_W-1:0]   eng_x,
  input  logic             eng_done,
  input  logic [F_W-1:0]   eng_fi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [X_W-1:0]   rsp_x,
  output logic [F_W-1:0]   rsp_fi,
  output logic             rsp_ovf,
  output logic             rsp_tmo,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_done
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // One extra bit so MAX_X values up to 2^(X_W+1)-1 compare correctly
  localparam logic [X_W:0]   MAX_X_L    = (X_W + 1)'(MAX_X);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               eng_start_q, eng_start_d;
  logic [X_W-1:0]     eng_x_q, eng_x_d;
  logic [F_W-1:0]     rsp_fi_q, rsp_fi_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_tmo_q, rsp_tmo_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   cnt_done_q, cnt_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_x_q     <= '0;
      rsp_fi_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      cnt_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      eng_start_q <= eng_start_d;
      eng_x_q     <= eng_x_d;
      rsp_fi_q    <= rsp_fi_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_tmo_q   <= rsp_tmo_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
      cnt_done_q  <= cnt_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    eng_x_d    = eng_x_q;
    rsp_fi_d   = rsp_fi_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_tmo_d  = rsp_tmo_q;
    timer_d    = timer_q;
    armed_d    = armed_q;
    cnt_done_d = cnt_done_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          eng_x_d = req_x;
          if ({1'b0, req_x} > MAX_X_L) begin
            rsp_fi_d  = '0;
            rsp_ovf_d = 1'b1;
            rsp_tmo_d = 1'b0;
            state_d   = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        timer_d = '0;
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A Done still high from the previous operation is ignored until it drops once
        if (!eng_done) armed_d = 1'b1;
        if (eng_done && armed_q) begin
          rsp_fi_d  = eng_fi;
          rsp_ovf_d = 1'b0;
          rsp_tmo_d = 1'b0;
          state_d   = RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_fi_d  = '0;
          rsp_ovf_d = 1'b0;
          rsp_tmo_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = IDLE;
          if (!rsp_ovf_q && !rsp_tmo_q) cnt_done_d = cnt_done_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state
  assign req_ready_d = (state_d == IDLE);
  assign rsp_valid_d = (state_d == RESP);
  assign eng_start_d = (state_d == START);

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;
  assign rsp_x     = eng_x_q;
  assign rsp_fi    = rsp_fi_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign busy      = (state_q != IDLE);
  assign cnt_done  = cnt_done_q;

endmodule

// File: doc/facto_requester.md
Name: facto_requester

Overview:
- Host-side initiator for the factorial engine interface (X, start_i, Done, fi_out).
- Accepts operands on a valid/ready request channel, launches one engine computation per operand, and waits for completion with a timeout.
- Returns {x, result, status} on a valid/ready response channel.
- Operands above MAX_X are rejected locally, without starting the engine.

Parameters:
- X_W, 4, operand width (engine X)
- F_W, 32, result width (engine fi_out)
- MAX_X, 12, largest operand whose factorial fits F_W; larger operands are rejected
- TIMEOUT, 1023, max cycles to wait for engine completion before abort
- CNT_W, 16, width of completion counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request operand valid
- req_ready  out  1  requester can accept operand
- req_x  in  X_W  operand
- eng_start  out  1  start pulse to engine (start_i)
- eng_x  out  X_W  operand to engine (X), held stable from start to completion
- eng_done  in  1  engine Done
- eng_fi  in  F_W  engine result (fi_out)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_x  out  X_W  operand echoed
- rsp_fi  out  F_W  factorial, 0 on reject/timeout
- rsp_ovf  out  1  operand > MAX_X, rejected
- rsp_tmo  out  1  engine timed out
- busy  out  1  state != IDLE
- cnt_done  out  CNT_W  count of successful responses, wraps at 2^CNT_W

Behaviour:
- Reset (async, any state): state=IDLE, and all of the following are 0: req_ready, eng_start, eng_x, rsp_valid, rsp_x, rsp_fi, rsp_ovf, rsp_tmo, busy, cnt_done, timer, armed. Reset mid-WAIT abandons the operation with no response. The engine is reset by the same rst.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch req_x into eng_x/rsp_x.
  - If req_x > MAX_X: go to RESP with rsp_fi=0, rsp_ovf=1, rsp_tmo=0. The engine is never started.
  - Otherwise: go to START.
- START:
  - eng_start=1 for exactly this one cycle.
  - timer cleared, armed=0.
  - Go to WAIT.
- WAIT:
  - timer increments each cycle.
  - armed sets on the first cycle with eng_done=0, which discards any stale Done left from the previous operation.
  - Completion is eng_done=1 with armed=1. On completion: capture eng_fi into rsp_fi, rsp_ovf=0, rsp_tmo=0, go to RESP.
  - If timer reaches TIMEOUT without completion: rsp_fi=0, rsp_tmo=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid=1. rsp_x, rsp_fi, rsp_ovf and rsp_tmo are held stable until the handshake.
  - On rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
  - cnt_done increments on the handshake only if rsp_ovf=0 and rsp_tmo=0.
  - A back-to-back request is accepted in the cycle after the handshake (req_ready is 0 outside IDLE). Minimum throughput is one operation per engine latency + 4 cycles.
- req_ready and rsp_valid are registered; there is no combinational path from req_valid or rsp_ready to them.
- eng_x is constant from START through leaving WAIT.
- Boundaries:
  - X=0 returns 1.
  - X=MAX_X is accepted; X=MAX_X+1 is rejected.
  - cnt_done wraps to 0 after its maximum value.

Test Plan:
- Reset, then req_x=5 → exactly one eng_start pulse with eng_x=5; after Done, rsp_valid=1, rsp_fi=120, rsp_ovf=0, rsp_tmo=0; cnt_done=1 after handshake.
- Operands 0, 1, 12 back-to-back with rsp_ready held high → responses 1, 1, 479001600 in order; cnt_done=3; eng_start pulses 3 times.
- req_x=13 → no eng_start; next cycle rsp_valid=1, rsp_fi=0, rsp_ovf=1; cnt_done unchanged.
- Engine model never asserts Done, TIMEOUT=15 → rsp_tmo=1 and rsp_fi=0, asserted 16 cycles after eng_start; a following req_x=3 then completes normally with rsp_fi=6.
- Stale Done: eng_done held high across the START cycle of a new req_x=4, then dropped and re-raised → response captured only on the re-raise, rsp_fi=24. Separately, rsp_ready=0 for 10 cycles → outputs stable and req_ready=0 throughout.
- Assert rst during WAIT → busy=0, rsp_valid=0, and cnt_done=0 asynchronously; no response is emitted; a new req_x=6 after release gives 720.
